// File: rtl/chunked_subtractor_if.sv
// Handshake and data bundle for chunked_subtractor.
// master drives operands and out_ready; slave is the subtractor.
interface chunked_subtractor_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             ovf;

   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, diff, borrow, ovf
   );

   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, diff, borrow, ovf
   );
endinterface

// File: rtl/chunked_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, CHUNK bits per clock,
// LSB chunk first, with the borrow rippled through a register.
// Operands are shifted right each RUN cycle so the active chunk is always
// at bit 0; result chunks enter diff from the top and settle after NCHUNK
// steps. The operand sign bits are kept aside for the overflow rule.
module chunked_subtractor #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   chunked_subtractor_if.slave bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] diff_q;
   logic             a_msb;
   logic             b_msb;
   logic             breg;
   logic             borrow_q;
   logic             ovf_q;
   logic [CW-1:0]    cnt;
   logic [CHUNK-1:0] dchunk;
   logic             bnext;
   logic             last;

   assign last = (cnt == CW'(NCHUNK - 1));

   // Subtract the current low chunk of each operand with the running borrow.
   always_comb begin
      {bnext, dchunk} = {1'b0, a_q[CHUNK-1:0]} - {1'b0, b_q[CHUNK-1:0]}
                        - {{CHUNK{1'b0}}, breg};
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: clocked state is updated with <= so every flop samples pre-edge values.
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: accept in IDLE, step per chunk, release on out_ready.
   always_comb begin
      // NOTE: default assigned first so no path through this block infers a latch.
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.in_valid) state_nxt = RUN;
         RUN:     if (last)         state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: latch operands, then one chunk per RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         a_msb    <= 1'b0;
         b_msb    <= 1'b0;
         breg     <= 1'b0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
         cnt      <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q   <= bus.a;
                  b_q   <= bus.b;
                  a_msb <= bus.a[WIDTH-1];
                  b_msb <= bus.b[WIDTH-1];
                  breg  <= bus.bin;
                  cnt   <= '0;
               end
            end
            RUN: begin
               a_q    <= a_q >> CHUNK;
               b_q    <= b_q >> CHUNK;
               diff_q <= (diff_q >> CHUNK) | (WIDTH'(dchunk) << (WIDTH - CHUNK));
               breg   <= bnext;
               cnt    <= last ? '0 : cnt + 1'b1;
               if (last) begin
                  // The last chunk carries the final diff MSB.
                  borrow_q <= bnext;
                  ovf_q    <= (a_msb != b_msb) && (dchunk[CHUNK-1] != a_msb);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.diff      = diff_q;
   assign bus.borrow    = borrow_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_chunked_subtractor.sv
// Bench for chunked_subtractor: directed vectors on a 16/4 instance plus a
// random sweep over several WIDTH/CHUNK combinations against a simple model.
module tb_chunked_subtractor;
   logic clk = 1'b0;
   logic rst_n;
   logic sw_rst_n;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Directed instance, WIDTH=16, CHUNK=4
   // ------------------------------------------------------------------
   chunked_subtractor_if #(.WIDTH(16)) mif ();
   chunked_subtractor #(.WIDTH(16), .CHUNK(4)) dut (.clk(clk), .rst_n(rst_n), .bus(mif));

   task automatic run_op(input string nm, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tbin, input logic [15:0] ed, input logic eb,
                         input logic eo, input bit rel);
      int lat;
      check({nm, "_in_ready"}, mif.in_ready, 1);
      mif.a = ta; mif.b = tb; mif.bin = tbin; mif.in_valid = 1'b1;
      @(posedge clk); #1 mif.in_valid = 1'b0;
      lat = 0;
      while (!mif.out_valid && lat < 50) begin
         @(posedge clk); #1 lat++;
      end
      check({nm, "_latency"}, lat, 4);
      check({nm, "_diff"}, mif.diff, ed);
      check({nm, "_borrow"}, mif.borrow, eb);
      check({nm, "_ovf"}, mif.ovf, eo);
      check({nm, "_busy"}, mif.in_ready, 0);
      if (rel) begin
         mif.out_ready = 1'b1;
         @(posedge clk); #1 mif.out_ready = 1'b0;
         check({nm, "_released"}, mif.out_valid, 0);
      end
   endtask

   // ------------------------------------------------------------------
   // Random sweep instances
   // ------------------------------------------------------------------
   localparam int NSW = 5;

   function automatic int sweep_w(int i);
      case (i)
         0: return 8;
         1: return 16;
         2: return 16;
         3: return 32;
         default: return 8;
      endcase
   endfunction

   function automatic int sweep_c(int i);
      case (i)
         0: return 1;
         1: return 8;
         2: return 16;
         3: return 16;
         default: return 8;
      endcase
   endfunction

   for (genvar g = 0; g < NSW; g++) begin : sw
      localparam int W = sweep_w(g);
      localparam int C = sweep_c(g);
      logic done;

      chunked_subtractor_if #(.WIDTH(W)) sif ();
      chunked_subtractor #(.WIDTH(W), .CHUNK(C)) dut (.clk(clk), .rst_n(sw_rst_n), .bus(sif));

      initial begin : drive
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         logic         rbin;
         logic [W:0]   model;
         longint       sdiff;
         logic         eovf;
         int           lat;
         done = 1'b0;
         sif.in_valid = 1'b0; sif.a = '0; sif.b = '0; sif.bin = 1'b0; sif.out_ready = 1'b0;
         wait (sw_rst_n === 1'b1);
         @(negedge clk);
         for (int n = 0; n < 1000; n++) begin
            if (n == 0) begin
               ra = '0; rb = '1; rbin = 1'b1;
            end else if (n == 1) begin
               ra = '1; rb = '0; rbin = 1'b0;
            end else begin
               ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
            end
            model = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
            sdiff = longint'($signed(ra)) - longint'($signed(rb)) - longint'(rbin);
            eovf  = (sdiff > ((longint'(1) <<< (W - 1)) - 1)) ||
                    (sdiff < -(longint'(1) <<< (W - 1)));
            check($sformatf("sw%0d_in_ready", g), sif.in_ready, 1);
            sif.a = ra; sif.b = rb; sif.bin = rbin; sif.in_valid = 1'b1;
            @(posedge clk); #1 sif.in_valid = 1'b0;
            lat = 0;
            while (!sif.out_valid && lat < 200) begin
               @(posedge clk); #1 lat++;
            end
            check($sformatf("sw%0d_latency", g), lat, W / C);
            check($sformatf("sw%0d_diff a=%0h b=%0h bin=%0d", g, ra, rb, rbin), sif.diff, model[W-1:0]);
            check($sformatf("sw%0d_borrow a=%0h b=%0h bin=%0d", g, ra, rb, rbin), sif.borrow, model[W]);
            check($sformatf("sw%0d_ovf a=%0h b=%0h bin=%0d", g, ra, rb, rbin), sif.ovf, eovf);
            sif.out_ready = 1'b1;
            @(posedge clk); #1 sif.out_ready = 1'b0;
         end
         done = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Directed sequence and summary
   // ------------------------------------------------------------------
   initial begin
      int waited;
      rst_n = 1'b0; sw_rst_n = 1'b0;
      mif.in_valid = 1'b0; mif.a = '0; mif.b = '0; mif.bin = 1'b0; mif.out_ready = 1'b0;
      #1;
      check("rst_in_ready", mif.in_ready, 1);
      check("rst_out_valid", mif.out_valid, 0);
      check("rst_diff", mif.diff, 0);
      check("rst_borrow", mif.borrow, 0);
      check("rst_ovf", mif.ovf, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1; sw_rst_n = 1'b1;
      @(posedge clk); #1;

      // out_ready while idle must not disturb anything
      mif.out_ready = 1'b1;
      @(posedge clk); #1 mif.out_ready = 1'b0;
      check("idle_out_ready", mif.in_ready, 1);

      run_op("basic",   16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
      run_op("ripple",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1);
      run_op("ovf_neg", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b1);
      run_op("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b1);

      // Hold the result with out_ready low while a new request is offered
      run_op("bin_in",  16'h0010, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
      mif.a = 16'hFFFF; mif.b = 16'h0000; mif.bin = 1'b0; mif.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("hold_out_valid", mif.out_valid, 1);
         check("hold_diff", mif.diff, 16'h0000);
         check("hold_borrow", mif.borrow, 0);
         check("hold_ovf", mif.ovf, 0);
         check("hold_in_ready", mif.in_ready, 0);
      end
      mif.in_valid = 1'b0;
      mif.out_ready = 1'b1;
      @(posedge clk); #1 mif.out_ready = 1'b0;
      check("release_out_valid", mif.out_valid, 0);
      check("release_in_ready", mif.in_ready, 1);
      check("release_diff_kept", mif.diff, 16'h0000);

      // Leave borrow/ovf at 1, then abort a run with reset in its 2nd cycle
      run_op("pre_rst", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b1);
      mif.a = 16'hFFFF; mif.b = 16'h0000; mif.bin = 1'b0; mif.in_valid = 1'b1;
      @(posedge clk); #1 mif.in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", mif.out_valid, 0);
      check("abort_diff", mif.diff, 0);
      check("abort_borrow", mif.borrow, 0);
      check("abort_ovf", mif.ovf, 0);
      check("abort_in_ready", mif.in_ready, 1);
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("abort_no_result", mif.out_valid, 0);
      end
      run_op("post_rst", 16'h00FF, 16'h0F00, 1'b0, 16'hF1FF, 1'b1, 1'b0, 1'b1);

      waited = 0;
      while (!(sw[0].done && sw[1].done && sw[2].done && sw[3].done && sw[4].done)
             && waited < 60000) begin
         @(posedge clk); waited++;
      end
      check("sweep_finished", waited < 60000, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/chunked_subtractor.md
Name: chunked_subtractor

Overview:
- Multi-cycle, parametrised WIDTH-bit subtractor computing diff = a - b - bin.
- Processes CHUNK bits per clock, LSB chunk first, rippling the borrow between chunks through an internal borrow register.
- Uses valid/ready handshakes on input and output. Reports the final borrow-out and the two's-complement signed overflow.
- Sits in the arithmetic library as the area-lean successor to the single-bit subtractor cells.

Parameters:
- WIDTH, 16, operand and result width in bits; must be ≥ 1.
- CHUNK, 4, bits processed per cycle; must satisfy 1 ≤ CHUNK ≤ WIDTH and WIDTH % CHUNK == 0.
- NCHUNK, WIDTH/CHUNK, derived local parameter, not overridable; number of RUN cycles per operation.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow-in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- diff  out  WIDTH  result, (a - b - bin) mod 2^WIDTH.
- borrow  out  1  borrow-out; 1 iff a < b + bin (unsigned).
- ovf  out  1  signed overflow flag.

Behaviour:
- Reset (rst_n low, asynchronous assert): state = IDLE, out_valid = 0, diff = 0, borrow = 0, ovf = 0, chunk counter = 0, internal operand registers = 0.
  - in_ready = (state == IDLE), so it reads 1 during and after reset.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch a, b; load borrow register with bin; counter = 0; go to RUN.
  - Otherwise stay in IDLE.
- RUN, one cycle per chunk, counter k = 0..NCHUNK-1:
  - {bnext, dchunk} = {1'b0, a[k]} - {1'b0, b[k]} - breg, computed at CHUNK+1 bits; a[k] and b[k] denote chunk k of the latched operands.
  - Write dchunk into diff chunk k; breg <= bnext; counter increments.
  - On the cycle with k == NCHUNK-1: go to DONE, set out_valid = 1, borrow = bnext, and ovf = (a[MSB] != b[MSB]) && (final diff[MSB] != a[MSB]).
  - in_ready = 0 throughout RUN.
- Intermediate diff chunks may be visible during RUN. diff, borrow and ovf are defined only while out_valid = 1.
- DONE:
  - out_valid = 1; diff, borrow and ovf held stable.
  - in_ready = 0.
  - On out_ready = 1: out_valid falls to 0 at the same edge; go to IDLE. diff, borrow and ovf retain their values until overwritten.
- Latency: operands accepted at edge E, out_valid high after edge E + NCHUNK. Minimum initiation interval is NCHUNK + 2 cycles.
- CHUNK == WIDTH: a single RUN cycle; the latency rule still holds.
- While not in IDLE, in_valid, a, b and bin are ignored; operands are taken only from the latched copies.
- out_ready asserted outside DONE has no effect.
- Reset asserted mid-RUN or in DONE: aborts immediately to the reset values above. No partial result is ever presented with out_valid = 1.
- No combinational path from in_valid or out_ready to any output.

Test Plan (WIDTH=16, CHUNK=4 unless noted):
- a=0x1234, b=0x0234, bin=0, accepted at edge E -> out_valid rises after edge E+4; diff=0x1000, borrow=0, ovf=0.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, borrow=1, ovf=0. Borrow ripples through all four chunks.
- a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, borrow=0, ovf=1. Also a=0x7FFF, b=0xFFFF -> diff=0x8000, borrow=1, ovf=1.
- a=0x0010, b=0x000F, bin=1 -> diff=0x0000, borrow=0.
  - Then hold out_ready=0 for 3 cycles: out_valid, diff, borrow and ovf stay stable; in_ready stays 0; a new in_valid with a=0xFFFF is ignored.
  - Then assert out_ready: out_valid falls, in_ready rises next cycle.
- Pulse rst_n low during the 2nd RUN cycle -> all outputs read 0 and in_ready=1 immediately. A following operation a=0x00FF, b=0x0F00, bin=0 gives diff=0xF1FF, borrow=1, ovf=0.
- Parameter sweep (CHUNK=1, 8, 16; WIDTH=8, 16, 32) with 1000 random operands each, compared against the model {borrow, diff} = {1'b0, a} - {1'b0, b} - bin.
  - Check ovf against the signed rule.
  - Check latency is exactly NCHUNK cycles.
